// File: rtl/mux8x1_rr.sv
// Eight-channel round-robin merge: each channel has a one-word skid slot, and a
// single registered output picks the next full slot after the last winner.
module mux8x1_rr #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  input  logic               out_ready
);

  logic [WIDTH-1:0] slot_data [8];
  logic [WIDTH-1:0] chan_data [8];
  logic [7:0]       full;
  logic [7:0]       accept;
  logic [7:0]       grant_onehot;
  logic [2:0]       last;
  logic [2:0]       search_idx;
  logic [2:0]       grant_idx;
  logic             grant_found;
  logic             out_free;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // in_ready depends only on the slot flags, never on out_ready or in_valid
  assign in_ready = ~full;
  assign accept   = in_valid & ~full;
  assign out_free = ~out_valid | out_ready;

  // First full slot scanning last+1 .. last+8 (mod 8)
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    search_idx  = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      search_idx = last + 3'(k);
      if (!grant_found && full[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx;
      end
    end
  end

  assign grant_onehot = (out_free && grant_found) ? (8'd1 << grant_idx) : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= 8'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 3'd0;
      last      <= 3'd7;
      for (int i = 0; i < 8; i++) begin
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (accept[i]) begin
          slot_data[i] <= chan_data[i];
        end
      end
      // A slot cannot be accepted into and granted from in the same cycle
      full <= (full | accept) & ~grant_onehot;
      if (out_free) begin
        if (grant_found) begin
          out_valid <= 1'b1;
          out_data  <= slot_data[grant_idx];
          out_sel   <= grant_idx;
          last      <= grant_idx;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux8x1_rr.sv
// Bench for mux8x1_rr: directed scenarios plus a random phase, all checked
// against a queue-based model of the channel slots and the output register.
module tb_mux8x1_rr;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [7:0]     in_valid = 8'd0;
  logic [8*W-1:0] in_data = '0;
  logic [7:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  // Reference model: one queue (depth <= 1) per channel and the output word
  logic [W-1:0] mq [8][$];
  logic         m_ov;
  logic [W-1:0] m_od;
  logic [2:0]   m_os;
  int           m_last;

  mux8x1_rr #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) mq[i].delete();
    m_ov = 1'b0;
    m_od = '0;
    m_os = 3'd0;
    m_last = 7;
  endtask

  task automatic model_update();
    int g;
    bit free;
    g = -1;
    if (rst_n) begin
      free = !m_ov || out_ready;
      if (free) begin
        for (int k = 1; k <= 8; k++) begin
          int c;
          c = (m_last + k) % 8;
          if (g < 0 && mq[c].size() > 0) g = c;
        end
      end
      for (int i = 0; i < 8; i++) begin
        if (in_valid[i] && mq[i].size() == 0) mq[i].push_back(in_data[i*W +: W]);
      end
      if (free) begin
        if (g >= 0) begin
          m_ov = 1'b1;
          m_od = mq[g].pop_front();
          m_os = 3'(g);
          m_last = g;
        end else begin
          m_ov = 1'b0;
        end
      end
    end
  endtask

  task automatic model_cmp();
    logic [7:0] er;
    for (int i = 0; i < 8; i++) er[i] = (mq[i].size() == 0);
    chk("model_in_ready", {24'd0, in_ready}, {24'd0, er});
    chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("model_out_data", {24'd0, out_data}, {24'd0, m_od});
    chk("model_out_sel", {29'd0, out_sel}, {29'd0, m_os});
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    model_cmp();
  endtask

  // Asserts reset between edges, holds it across one edge, releases mid-cycle
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_sel", {29'd0, out_sel}, 32'd0);
    chk("rst_in_ready", {24'd0, in_ready}, 32'hFF);
    @(posedge clk);
    model_update();
    #1;
    model_cmp();
    chk("rst_no_accept", {24'd0, in_ready}, 32'hFF);
    in_valid = 8'd0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] d);
    in_data[i*W +: W] = d;
  endtask

  initial begin
    do_reset();

    // Single word on channel 3
    out_ready = 1'b1;
    in_valid = 8'h08; set_ch(3, 8'hA5);
    step();
    chk("single_accept_valid", {31'd0, out_valid}, 32'd0);
    chk("single_accept_ready", {24'd0, in_ready}, 32'hF7);
    in_valid = 8'd0;
    step();
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data", {24'd0, out_data}, 32'hA5);
    chk("single_sel", {29'd0, out_sel}, 32'd3);
    chk("single_ready", {24'd0, in_ready}, 32'hFF);
    step();
    chk("single_done", {31'd0, out_valid}, 32'd0);
    $display("[TB] single word ch3 done");

    // All eight full at once: grants 0..7 in order
    do_reset();
    out_ready = 1'b1;
    in_valid = 8'hFF;
    for (int i = 0; i < 8; i++) set_ch(i, 8'(8'h10 + i));
    step();
    in_valid = 8'd0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("fair_valid", {31'd0, out_valid}, 32'd1);
      chk("fair_sel", {29'd0, out_sel}, 32'(i));
      chk("fair_data", {24'd0, out_data}, 32'(8'h10 + i));
    end
    step();
    chk("fair_done", {31'd0, out_valid}, 32'd0);
    $display("[TB] all-full fairness done");

    // Backpressure with ch5 and ch6 buffered
    do_reset();
    out_ready = 1'b0;
    in_valid = 8'h60; set_ch(5, 8'h55); set_ch(6, 8'h66);
    step();
    in_valid = 8'h20; set_ch(5, 8'h5A);
    step();
    step();
    in_valid = 8'd0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data", {24'd0, out_data}, 32'h55);
      chk("bp_sel", {29'd0, out_sel}, 32'd5);
      chk("bp_ready65", {30'd0, in_ready[6:5]}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_rel_data", {24'd0, out_data}, 32'h66);
    chk("bp_rel_sel", {29'd0, out_sel}, 32'd6);
    step();
    chk("bp_rel2_data", {24'd0, out_data}, 32'h5A);
    step();
    chk("bp_done", {31'd0, out_valid}, 32'd0);
    $display("[TB] backpressure done");

    // Wrap-around from last=6
    do_reset();
    out_ready = 1'b1;
    in_valid = 8'h40; set_ch(6, 8'h06);
    step();
    in_valid = 8'd0;
    step();
    chk("wrap_sel6", {29'd0, out_sel}, 32'd6);
    in_valid = 8'h82; set_ch(7, 8'h77); set_ch(1, 8'h11);
    step();
    in_valid = 8'd0;
    step();
    chk("wrap_first7", {29'd0, out_sel}, 32'd7);
    step();
    chk("wrap_then1", {29'd0, out_sel}, 32'd1);
    in_valid = 8'h03; set_ch(0, 8'h0A); set_ch(1, 8'h1B);
    step();
    in_valid = 8'd0;
    step();
    chk("wrap_first0", {29'd0, out_sel}, 32'd0);
    chk("wrap_data0", {24'd0, out_data}, 32'h0A);
    step();
    chk("wrap_then1b", {29'd0, out_sel}, 32'd1);
    chk("wrap_data1", {24'd0, out_data}, 32'h1B);
    $display("[TB] wrap-around done");

    // Overwrite attempt on a full slot
    do_reset();
    out_ready = 1'b0;
    in_valid = 8'h10; set_ch(4, 8'h44);
    step();
    in_valid = 8'h04; set_ch(2, 8'h22);
    step();
    set_ch(2, 8'hFF);
    step();
    chk("ovw_ready2", {31'd0, in_ready[2]}, 32'd0);
    step();
    chk("ovw_ready2b", {31'd0, in_ready[2]}, 32'd0);
    chk("ovw_hold", {24'd0, out_data}, 32'h44);
    in_valid = 8'd0;
    out_ready = 1'b1;
    step();
    chk("ovw_data", {24'd0, out_data}, 32'h22);
    chk("ovw_sel", {29'd0, out_sel}, 32'd2);
    step();
    chk("ovw_done", {31'd0, out_valid}, 32'd0);
    $display("[TB] overwrite attempt done");

    // Reset in the middle of traffic
    do_reset();
    out_ready = 1'b0;
    in_valid = 8'h1F;
    for (int i = 0; i < 5; i++) set_ch(i, 8'(8'h30 + i));
    step();
    in_valid = 8'd0;
    step();
    chk("mid_busy", {31'd0, out_valid}, 32'd1);
    chk("mid_full", {24'd0, in_ready}, 32'hE1);
    in_valid = 8'hFF;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("mid_no_stale", {31'd0, out_valid}, 32'd0);
    end
    $display("[TB] reset mid-stream done");

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid = 8'($urandom);
      in_data = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 8'd0;
    out_ready = 1'b1;
    repeat (10) step();
    chk("rand_drained", {31'd0, out_valid}, 32'd0);
    $display("[TB] random traffic done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux8x1_rr.md
MUX8X1_RR -- requirements
Module: mux8x1_rr

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width of every channel and of the output.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  8  bit i = channel i offers a word.
REQ-005 SHALL have port: in_data  input  8*WIDTH  channel i word in bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port: in_ready  output  8  bit i = channel i buffer can accept.
REQ-007 SHALL have port: out_valid  output  1  out_data/out_sel hold a word.
REQ-008 SHALL have port: out_data  output  WIDTH  selected word.
REQ-009 SHALL have port: out_sel  output  3  source channel of out_data, same encoding as demux select {s2,s1,s0}.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts the current word.

Function
REQ-011 SHALL hold one single-entry buffer (data + full flag) per channel.
REQ-012 SHALL drive in_ready[i] = ~full[i], from registers only, with no combinational path from out_ready or in_valid.
REQ-013 SHALL capture in_data channel i and set full[i] at an edge where in_valid[i] & in_ready[i].
REQ-014 SHALL hold one output register (out_valid, out_data, out_sel), free when out_valid=0 or out_ready=1.
REQ-015 SHALL keep a 3-bit round-robin pointer last; search order last+1, last+2, ... last+8, modulo 8 (wraps 7->0).
REQ-016 SHALL, at an edge where the output register is free and any full[i]=1, grant the first full channel in search order: load out_data=buffer[g], out_sel=g, set out_valid=1, clear full[g], set last=g.
REQ-017 SHALL, at an edge where the output register is free and no buffer is full, clear out_valid; out_data/out_sel retain the last values.
REQ-018 SHALL hold out_valid, out_data, and out_sel stable while out_valid=1 and out_ready=0; no buffer is cleared and last is unchanged.
REQ-019 SHALL ignore in_data and in_valid on a channel whose buffer is full; the stored word is not overwritten.
REQ-020 SHALL give a latency of exactly one edge from accept edge to out_valid when the output register is free and no other channel wins: accepted at edge k, out_valid=1 after edge k+1.
REQ-021 SHALL allow simultaneous accept on any subset of channels and grant of another channel in the same cycle.
REQ-022 SHALL let a granted channel accept a new word no earlier than the edge after the grant, because in_ready rises after full clears.
REQ-023 SHALL sustain one output word per cycle while out_ready=1 and at least one buffer is full.
REQ-024 SHALL grant each continuously full channel at least once in every 8 consecutive grants.
REQ-025 SHALL never lose, duplicate, or reorder words within a channel.

Reset
REQ-026 SHALL, while rst_n=0, regardless of clk, force: full[7:0]=0 (in_ready=8'hFF), out_valid=0, out_data=0, out_sel=0, last=7 (channel 0 has first priority).
REQ-027 SHALL discard buffered and output words when reset asserts mid-operation, and SHALL emit no word until new input is accepted after rst_n rises.
REQ-028 SHALL accept no input at an edge where rst_n=0.

Verification
REQ-029 SHALL cover single word: after reset, ch3 in_valid with data 8'hA5 for one edge, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_sel=3, in_ready=8'hFF; following cycle out_valid=0.
REQ-030 SHALL cover all-full fairness: all 8 channels loaded with 8'h10+i in one edge, out_ready=1 -> out_sel sequence 0,1,...,7 on 8 consecutive cycles with matching data, then out_valid=0.
REQ-031 SHALL cover backpressure: ch5=8'h55 and ch6=8'h66 buffered, out_ready=0 for 4 cycles -> out_sel=5, out_data=8'h55 held stable, in_ready[6:5]=0; release -> 8'h55 then 8'h66 on consecutive cycles.
REQ-032 SHALL cover wrap-around: last=6, ch7 and ch1 full -> ch7 granted before ch1; then with ch0 and ch1 full -> ch0 before ch1.
REQ-033 SHALL cover full-buffer overwrite attempt: ch2 holds 8'h22 with out_ready=0, drive in_valid[2] with 8'hFF -> in_ready[2]=0, output later shows 8'h22 only.
REQ-034 SHALL cover reset mid-stream: assert rst_n=0 asynchronously between edges with 4 buffers full and out_valid=1 -> immediately out_valid=0, out_data=0, out_sel=0, in_ready=8'hFF; no stale word after release.
